// File: rtl/dilate_sequencer.sv
// ---------------------------------------------------------------------------
// dilate_sequencer
//
// Sequences a 32x32 binary frame through an external combinational dilation
// datapath a programmable number of times. The frame register feeds the
// datapath (proc_in); each RUN cycle loads the datapath result (proc_out)
// back into the frame register and counts down the remaining passes.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Once valid is raised the payload is held stable until that
// edge. The input side is ready only in IDLE. The output side is valid only
// in DONE. abort overrides both handshakes.
//
// Ports
//   clk, rst_n   : clock and asynchronous active-low reset
//   in_valid     : producer offers a frame
//   in_ready     : block can take a frame (IDLE only)
//   in_image     : 32x32 frame, bit index = row*32+col
//   passes       : dilation pass count, sampled on accept
//   abort        : synchronous cancel, returns to IDLE on the next edge
//   proc_in      : frame register, drives the external datapath
//   proc_out     : datapath result for proc_in, same cycle
//   out_valid    : result available (DONE only)
//   out_ready    : consumer takes the result
//   out_image    : frame register, qualified by out_valid
//   out_flipped  : odd pass count, result is bit-reversed relative to input
//   busy         : any state other than IDLE
// ---------------------------------------------------------------------------
module dilate_sequencer #(
  parameter int PASS_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1023:0]     in_image,
  input  logic [PASS_W-1:0] passes,
  input  logic              abort,
  output logic [1023:0]     proc_in,
  input  logic [1023:0]     proc_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1023:0]     out_image,
  output logic              out_flipped,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [PASS_W-1:0] CNT_ZERO = '0;
  localparam logic [PASS_W-1:0] CNT_ONE  = 1;

  logic [1:0]        state_q, state_d;
  logic [1023:0]     frame_q, frame_d;
  logic [PASS_W-1:0] cnt_q,   cnt_d;
  logic              flip_q,  flip_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      flip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      flip_q  <= flip_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    flip_d  = flip_q;

    if (abort) begin
      // Cancel wins over accept and output handshake; the frame is kept.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            frame_d = in_image;
            cnt_d   = passes;
            flip_d  = passes[0];
            state_d = (passes != CNT_ZERO) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          frame_d = proc_out;
          // Guarded so the counter can never wrap below zero.
          if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
          if (cnt_q <= CNT_ONE)  state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid   = (state_q == S_DONE);
    busy        = (state_q != S_IDLE);
    proc_in     = frame_q;
    out_image   = frame_q;
    out_flipped = flip_q;
  end

endmodule

// File: tb/tb_dilate_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dilate_sequencer
//
// Self-checking bench for dilate_sequencer. A behavioural dilation datapath
// is attached to proc_in/proc_out: it mirrors the frame (bit j <- bit
// 1023-j) and ORs a fixed neighbourhood on the linear bit index. Expected
// results are the datapath function applied 'passes' times to the input.
// ---------------------------------------------------------------------------
module tb_dilate_sequencer;

  localparam int PASS_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1023:0]     in_image;
  logic [PASS_W-1:0] passes;
  logic              abort;
  logic [1023:0]     proc_in;
  logic [1023:0]     proc_out;
  logic              out_valid;
  logic              out_ready;
  logic [1023:0]     out_image;
  logic              out_flipped;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic [1023:0] exp_q[$];
  logic          exp_flip_q[$];

  dilate_sequencer #(.PASS_W(PASS_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_image    (in_image),
    .passes      (passes),
    .abort       (abort),
    .proc_in     (proc_in),
    .proc_out    (proc_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_image   (out_image),
    .out_flipped (out_flipped),
    .busy        (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- dilation datapath ----------------
  function automatic logic [1023:0] dp(input logic [1023:0] img);
    int offs[10] = '{0, 1, 31, 32, -31, -32, -33, -34, -64, -65};
    logic [1023:0] r;
    r = '0;
    for (int j = 0; j < 1024; j++) begin
      for (int k = 0; k < 10; k++) begin
        int idx;
        idx = (((j + offs[k]) % 1024) + 1024) % 1024;
        if (img[1023 - idx]) r[j] = 1'b1;
      end
    end
    return r;
  endfunction

  assign proc_out = dp(proc_in);

  // ---------------- reference model ----------------
  function automatic logic [1023:0] ref_result(input logic [1023:0] img, input int p);
    logic [1023:0] r;
    r = img;
    for (int i = 0; i < p; i++) r = dp(r);
    return r;
  endfunction

  function automatic logic [1023:0] rand_img();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- checkers ----------------
  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_img(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    int first;
    checks++;
    assert (obs === exp) else begin
      errors++;
      first = -1;
      for (int i = 1023; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
      $error("FAIL %s: observed ones=%0d word0=%h, expected ones=%0d word0=%h, first diff bit=%0d",
             tag, $countones(obs), obs[31:0], $countones(exp), exp[31:0], first);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers a frame in IDLE and returns just after the accept edge.
  task automatic accept_frame(input logic [1023:0] img, input int p);
    in_valid = 1'b1;
    in_image = img;
    passes   = PASS_W'(p);
    chk_bit("in_ready_before_accept", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_image = rand_img();
  endtask

  // Counts cycles from the accept cycle up to out_valid, then checks result.
  task automatic wait_done(input int p);
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      chk_bit("busy_while_running", busy, 1'b1);
      step();
      lat++;
    end
    chk_int("latency", lat, p + 1);
    chk_bit("in_ready_in_done", in_ready, 1'b0);
    if (exp_q.size() > 0) begin
      chk_img("out_image", out_image, exp_q.pop_front());
      chk_bit("out_flipped", out_flipped, exp_flip_q.pop_front());
    end
  endtask

  // Holds the result for 'hold' cycles with in_valid noise, then hands off.
  task automatic finish_job(input int hold);
    logic [1023:0] snap;
    snap = out_image;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_image = rand_img();
      passes   = PASS_W'($urandom_range(0, 3));
      step();
      chk_bit("hold_out_valid", out_valid, 1'b1);
      chk_bit("hold_in_ready", in_ready, 1'b0);
      chk_img("hold_out_image", out_image, snap);
    end
    // in_valid stays high across the handshake edge; it must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk_bit("post_handshake_busy", busy, 1'b0);
    chk_bit("post_handshake_in_ready", in_ready, 1'b1);
    chk_bit("post_handshake_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [1023:0] img, input int p, input int hold);
    exp_q.push_back(ref_result(img, p));
    exp_flip_q.push_back(p[0]);
    accept_frame(img, p);
    wait_done(p);
    finish_job(hold);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1023:0] img;
    logic [1023:0] exp030;
    int bits030[10] = '{1023, 1022, 992, 991, 64, 63, 33, 32, 31, 30};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_image  = '0;
    passes    = '0;
    abort     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) step();
    chk_bit("reset_in_ready", in_ready, 1'b1);
    chk_bit("reset_out_valid", out_valid, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_out_flipped", out_flipped, 1'b0);
    chk_img("reset_out_image", out_image, '0);
    chk_img("reset_proc_in", proc_in, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single set pixel, one pass
    exp030 = '0;
    foreach (bits030[i]) exp030[bits030[i]] = 1'b1;
    img = '0;
    img[0] = 1'b1;
    exp_q.push_back(exp030);
    exp_flip_q.push_back(1'b1);
    accept_frame(img, 1);
    wait_done(1);
    finish_job(0);

    // Zero passes: pass-through
    img = '0;
    img[7:0] = 8'hA5;
    run_job(img, 0, 1);

    // Three passes
    run_job(rand_img(), 3, 0);

    // Result held for 10 cycles with in_valid noise
    run_job(rand_img(), 2, 10);

    // Abort in the second RUN cycle of a 3-pass job
    img = rand_img();
    accept_frame(img, 3);
    chk_bit("abort_run1_busy", busy, 1'b1);
    step();
    chk_bit("abort_run2_busy", busy, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_bit("abort_in_ready", in_ready, 1'b1);
    chk_bit("abort_busy", busy, 1'b0);
    chk_img("abort_frame_kept", out_image, dp(img));
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bit("abort_no_out_valid", out_valid, 1'b0);
    end

    // Abort beats a simultaneous accept
    in_valid = 1'b1;
    in_image = rand_img();
    passes   = 2'd1;
    abort    = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk_bit("abort_vs_accept_busy", busy, 1'b0);

    // Abort from DONE without out_ready
    img = rand_img();
    accept_frame(img, 0);
    chk_bit("done_before_abort", out_valid, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_bit("abort_done_out_valid", out_valid, 1'b0);
    chk_bit("abort_done_in_ready", in_ready, 1'b1);

    // Asynchronous reset mid-RUN, between clock edges
    accept_frame(rand_img(), 3);
    chk_bit("pre_reset_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_in_ready", in_ready, 1'b1);
    chk_bit("async_rst_busy", busy, 1'b0);
    chk_bit("async_rst_out_valid", out_valid, 1'b0);
    chk_bit("async_rst_out_flipped", out_flipped, 1'b0);
    chk_img("async_rst_out_image", out_image, '0);
    chk_img("async_rst_proc_in", proc_in, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_job(rand_img(), 1, 2);

    // Randomized jobs
    for (int n = 0; n < 8; n++) begin
      run_job(rand_img(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
